spi_master_link: RTL and testbench

Host-side counterpart of the SPI slave link: an SPI master that frames a service-protocol packet and drives it onto the SPI bus while capturing the slave's reply words. It pops payload words from the outgoing queue, prepends the address/command and size header, optionally appends a checksum, and pushes every word received on MISO into the incoming queue. It is used on test boards and in the bridge FPGA that talks to the mil1553-spi device.

---
 rtl/ServiceProtocol.sv | 18 +
 rtl/spi_word_shifter.sv | 98 +++++++++
 rtl/spi_master_link.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_link.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ServiceProtocol.sv
// rtl/ServiceProtocol.sv - service-protocol types shared by the SPI master link
package ServiceProtocol;
  localparam int SPI_WORD_WIDTH = 16;

  typedef logic [7:0] TCommandCode;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    LOAD,
    SHIFT,
    CS_HOLD
  } TSpiMasterState;

  function automatic logic [SPI_WORD_WIDTH-1:0] header_word(input logic [7:0] dst, input TCommandCode code);
    return {dst, code};
  endfunction
endpackage

// File: rtl/spi_word_shifter.sv
// rtl/spi_word_shifter.sv - SPI mode-0 word engine: SCLK divider, 16-bit shift registers, edge counter
module spi_word_shifter
  import ServiceProtocol::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [SPI_WORD_WIDTH-1:0] load_data,
  output logic                      busy,
  output logic                      word_done,
  output logic                      rx_valid,
  output logic [SPI_WORD_WIDTH-1:0] rx_word,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso
);
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] EDGE_LAST = 5'(2 * SPI_WORD_WIDTH - 1);
  localparam logic [4:0] RISE_LAST = 5'(2 * SPI_WORD_WIDTH - 2);

  logic                      busy_q, busy_d;
  logic [7:0]                div_q, div_d;
  logic [4:0]                edge_q, edge_d;
  logic                      sclk_q, sclk_d;
  logic [SPI_WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_WORD_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_WORD_WIDTH-1:0] rx_word_q, rx_word_d;
  logic                      rx_valid_q, rx_valid_d;

  // Even edge counts are rising edges; the 32nd toggle (count 31) is the final falling edge.
  assign word_done = busy_q && (div_q == DIV_LAST) && (edge_q == EDGE_LAST);
  assign busy      = busy_q;
  assign rx_valid  = rx_valid_q;
  assign rx_word   = rx_word_q;
  assign sclk      = sclk_q;
  assign mosi      = tx_sr_q[SPI_WORD_WIDTH-1];

  always_comb begin
    busy_d     = busy_q;
    div_d      = div_q;
    edge_d     = edge_q;
    sclk_d     = sclk_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_word_d  = rx_word_q;
    rx_valid_d = 1'b0;
    if (load) begin
      busy_d  = 1'b1;
      div_d   = '0;
      edge_d  = '0;
      sclk_d  = 1'b0;
      tx_sr_d = load_data;
    end else if (busy_q) begin
      div_d = div_q + 8'd1;
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        edge_d = edge_q + 5'd1;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_sr_d = {rx_sr_q[SPI_WORD_WIDTH-2:0], miso};
          if (edge_q == RISE_LAST) begin
            rx_word_d  = {rx_sr_q[SPI_WORD_WIDTH-2:0], miso};
            rx_valid_d = 1'b1;
          end
        end else begin
          tx_sr_d = {tx_sr_q[SPI_WORD_WIDTH-2:0], 1'b0};
          if (edge_q == EDGE_LAST) begin
            busy_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      div_q      <= '0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      sclk_q     <= sclk_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
    end
  end
endmodule

// File: rtl/spi_master_link.sv
// rtl/spi_master_link.sv - SPI master framing service-protocol packets from/to word queues
// Optional SPI_MASTER_CHECKSUM_EN appends a mod-2^16 sum of all sent frame words.
module spi_master_link
  import ServiceProtocol::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                addr,
  input  logic [7:0]                cmd_code,
  input  logic [15:0]               data_size,
  input  logic [SPI_WORD_WIDTH-1:0] tx_data,
  input  logic                      tx_empty,
  output logic                      tx_pop,
  output logic [SPI_WORD_WIDTH-1:0] rx_data,
  output logic                      rx_push,
  input  logic                      rx_full,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso,
  output logic                      spi_ncs,
  output logic                      busy,
  output logic                      done,
  output logic                      rx_overflow
);
  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
`ifdef SPI_MASTER_CHECKSUM_EN
  localparam logic [16:0] TRAILER_WORDS = 17'd1;
`else
  localparam logic [16:0] TRAILER_WORDS = 17'd0;
`endif

  TSpiMasterState            state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [SPI_WORD_WIDTH-1:0] hdr_q, hdr_d;
  logic [15:0]               size_q, size_d;
  logic [16:0]               idx_q, idx_d;
  logic                      ncs_q, ncs_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;

  logic                      sh_busy, sh_word_done, sh_rx_valid;
  logic [SPI_WORD_WIDTH-1:0] sh_rx_word, load_word, sum_word;
  logic [16:0]               payload_end, n_words;
  logic                      is_payload, accept, load_fire;

  assign payload_end = {1'b0, size_q} + 17'd2;
  assign n_words     = payload_end + TRAILER_WORDS;
  assign is_payload  = (idx_q >= 17'd2) && (idx_q < payload_end);
  assign accept      = (state_q == IDLE) && !busy_q && start;
  // Payload fetch stalls in LOAD on an empty queue; fixed words never stall.
  assign load_fire   = (state_q == LOAD) && !sh_busy && (!is_payload || !tx_empty);
  assign tx_pop      = load_fire && is_payload;

  always_comb begin
    if (idx_q == 17'd0)      load_word = hdr_q;
    else if (idx_q == 17'd1) load_word = size_q;
    else if (is_payload)     load_word = tx_data;
    else                     load_word = sum_word;
  end

`ifdef SPI_MASTER_CHECKSUM_EN
  logic [SPI_WORD_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept)         sum_d = '0;
    else if (load_fire) sum_d = sum_q + load_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign sum_word = sum_q;
`else
  assign sum_word = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    size_d  = size_q;
    idx_d   = idx_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (sh_rx_valid & rx_full);
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start) begin
          state_d = CS_SETUP;
          busy_d  = 1'b1;
          ncs_d   = 1'b0;
          ovf_d   = 1'b0;
          hdr_d   = header_word(addr, cmd_code);
          size_d  = data_size;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      CS_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LOAD: begin
        if (load_fire) begin
          idx_d   = idx_q + 17'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sh_word_done) state_d = (idx_q == n_words) ? CS_HOLD : LOAD;
      end
      CS_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  spi_word_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst),
    .load      (load_fire),
    .load_data (load_word),
    .busy      (sh_busy),
    .word_done (sh_word_done),
    .rx_valid  (sh_rx_valid),
    .rx_word   (sh_rx_word),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .miso      (spi_miso)
  );

  assign rx_push     = sh_rx_valid & ~rx_full;
  assign rx_data     = sh_rx_word;
  assign spi_ncs     = ncs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rx_overflow = ovf_q;
endmodule

// File: tb/tb_spi_master_link.sv
// tb/tb_spi_master_link.sv - directed self-checking bench for spi_master_link with an SPI slave model
`timescale 1ns/1ps
module tb_spi_master_link;
  localparam int CD       = 4;
  localparam int WORD_CYC = 32 * CD + 1;
`ifdef SPI_MASTER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, tx_empty, tx_pop, rx_push, rx_full;
  logic [7:0]  addr, cmd_code;
  logic [15:0] data_size, tx_data, rx_data;
  logic        spi_sclk, spi_mosi, spi_miso, spi_ncs, busy, done, rx_overflow;

  always #5 clk = ~clk;

  spi_master_link #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .cmd_code(cmd_code),
    .data_size(data_size), .tx_data(tx_data), .tx_empty(tx_empty), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_push(rx_push), .rx_full(rx_full), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ncs(spi_ncs), .busy(busy),
    .done(done), .rx_overflow(rx_overflow)
  );

  // Outgoing queue model
  logic [15:0] tx_mem [0:7];
  logic [2:0]  tx_rd = 3'd0;
  logic [2:0]  tx_wr;
  assign tx_empty = (tx_rd == tx_wr);
  assign tx_data  = tx_mem[tx_rd];

  int          cyc = 0, done_cnt = 0, pop_cnt = 0;
  logic [15:0] rx_words [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (tx_pop) begin
      pop_cnt <= pop_cnt + 1;
      tx_rd   <= tx_rd + 3'd1;
    end
    if (rx_push) rx_words.push_back(rx_data);
  end

  // SPI slave: captures MOSI on rising SCLK, shifts its reply word out MSB first
  logic [15:0] slave_reply;
  logic [15:0] mosi_sr = 16'h0;
  logic [3:0]  nbits = 4'd0;
  logic [15:0] mosi_words [$];
  assign spi_miso = slave_reply[4'd15 - nbits];
  always @(posedge spi_sclk or negedge spi_ncs) begin
    if (spi_sclk) begin
      mosi_sr <= {mosi_sr[14:0], spi_mosi};
      nbits   <= nbits + 4'd1;
      if (nbits == 4'd15) mosi_words.push_back({mosi_sr[14:0], spi_mosi});
    end else begin
      nbits <= 4'd0;
    end
  end

  int n_checks = 0, n_errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          t_start, base_mosi, base_rx, base_done, base_pop;
  logic [15:0] exp_w [$];

  task automatic push_tx(input logic [15:0] w);
    tx_mem[tx_wr] = w;
    tx_wr = tx_wr + 3'd1;
  endtask

  task automatic begin_frame(input logic [7:0] a, input logic [7:0] c, input logic [15:0] n);
    @(negedge clk);
    base_mosi = mosi_words.size();
    base_rx   = rx_words.size();
    base_done = done_cnt;
    base_pop  = pop_cnt;
    addr = a; cmd_code = c; data_size = n; start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int t_done);
    bit seen = 1'b0;
    t_done = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) begin
        seen   = 1'b1;
        t_done = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_mosi(input string tag, input int n);
    int k = 0;
    while (mosi_words.size() < base_mosi + n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(mosi_words.size() >= base_mosi + n), 32'd1);
  endtask

  task automatic check_words(input string tag);
    check_eq({tag, "_nwords"}, 32'(mosi_words.size() - base_mosi), 32'(exp_w.size()));
    foreach (exp_w[i])
      if (base_mosi + i < mosi_words.size())
        check_eq($sformatf("%s_w%0d", tag, i), 32'(mosi_words[base_mosi + i]), 32'(exp_w[i]));
  endtask

  task automatic check_replies(input string tag, input int n, input logic [15:0] w);
    check_eq({tag, "_npush"}, 32'(rx_words.size() - base_rx), 32'(n));
    for (int i = base_rx; i < rx_words.size(); i++)
      check_eq($sformatf("%s_rx%0d", tag, i - base_rx), 32'(rx_words[i]), 32'(w));
  endtask

  initial begin
    int t_done, toggles, ncs_high, pops_seen;
    logic sclk_prev;
    rst = 1'b0; start = 1'b0; addr = '0; cmd_code = '0; data_size = '0;
    rx_full = 1'b0; slave_reply = 16'h3C5A; tx_wr = 3'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ncs", spi_ncs, 1'b1);
    check_eq("rst_sclk", spi_sclk, 1'b0);
    check_eq("rst_mosi", spi_mosi, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ovf", rx_overflow, 1'b0);
    check_eq("rst_rx_data", rx_data, 16'h0);
    check_eq("rst_tx_pop", tx_pop, 1'b0);
    check_eq("rst_rx_push", rx_push, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame; a second start mid-frame must be ignored
    push_tx(16'hAAAA);
    push_tx(16'h5555);
    begin_frame(8'h12, 8'h01, 16'd2);
    check_eq("t1_ncs_low", spi_ncs, 1'b0);
    check_eq("t1_busy", busy, 1'b1);
    repeat (200) @(negedge clk);
    addr = 8'hFF; cmd_code = 8'hEE; data_size = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1", t_done);
    check_eq("t1_latency", 32'(t_done - t_start), 32'(2 * CD + 1 + (4 + CK) * WORD_CYC));
    check_eq("t1_ncs_at_done", spi_ncs, 1'b1);
    @(negedge clk);
    check_eq("t1_busy_after", busy, 1'b0);
    check_eq("t1_done_once", 32'(done_cnt - base_done), 32'd1);
    check_eq("t1_pops", 32'(pop_cnt - base_pop), 32'd2);
    exp_w = '{16'h1201, 16'h0002, 16'hAAAA, 16'h5555};
    if (CK != 0) exp_w.push_back(16'h1202);
    check_words("t1");
    check_replies("t1", 4 + CK, 16'h3C5A);

    // Empty payload
    begin_frame(8'h34, 8'h07, 16'd0);
    wait_done("t2", t_done);
    check_eq("t2_latency", 32'(t_done - t_start), 32'(2 * CD + 1 + (2 + CK) * WORD_CYC));
    @(negedge clk);
    check_eq("t2_pops", 32'(pop_cnt - base_pop), 32'd0);
    exp_w = '{16'h3407, 16'h0000};
    if (CK != 0) exp_w.push_back(16'h3407);
    check_words("t2");

    // Queue underrun before the second payload word
    push_tx(16'h1111);
    begin_frame(8'hA5, 8'h0F, 16'd3);
    for (int k = 0; k < 1000 && pop_cnt == base_pop; k++) @(negedge clk);
    check_eq("t3_first_pop", 32'(pop_cnt - base_pop), 32'd1);
    repeat (140) @(negedge clk);
    toggles = 0; ncs_high = 0; pops_seen = pop_cnt;
    sclk_prev = spi_sclk;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (spi_sclk != sclk_prev) toggles++;
      if (spi_ncs) ncs_high++;
      sclk_prev = spi_sclk;
    end
    check_eq("t3_sclk_static", 32'(toggles), 32'd0);
    check_eq("t3_sclk_low", spi_sclk, 1'b0);
    check_eq("t3_ncs_held", 32'(ncs_high), 32'd0);
    check_eq("t3_no_pop_stall", 32'(pop_cnt - pops_seen), 32'd0);
    push_tx(16'h2222);
    push_tx(16'h3333);
    wait_done("t3", t_done);
    @(negedge clk);
    exp_w = '{16'hA50F, 16'h0003, 16'h1111, 16'h2222, 16'h3333};
    if (CK != 0) exp_w.push_back(16'h0B78);
    check_words("t3");

    // Incoming queue full during the third word
    slave_reply = 16'hC3C3;
    push_tx(16'hAAAA);
    push_tx(16'h5555);
    begin_frame(8'h12, 8'h01, 16'd2);
    wait_mosi("t4_word2", 2);
    repeat (2) @(negedge clk);
    check_eq("t4_ovf_before", rx_overflow, 1'b0);
    rx_full = 1'b1;
    wait_mosi("t4_word3", 3);
    repeat (2) @(negedge clk);
    rx_full = 1'b0;
    check_eq("t4_ovf_set", rx_overflow, 1'b1);
    wait_done("t4", t_done);
    repeat (5) @(negedge clk);
    check_eq("t4_ovf_sticky", rx_overflow, 1'b1);
    check_replies("t4", 3 + CK, 16'hC3C3);

    // Reset in the middle of the size word, then a clean frame
    push_tx(16'h0F0F);
    begin_frame(8'h5A, 8'h3C, 16'd1);
    check_eq("t5_ovf_cleared", rx_overflow, 1'b0);
    wait_mosi("t5_word1", 1);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_ncs", spi_ncs, 1'b1);
    check_eq("t5_rst_sclk", spi_sclk, 1'b0);
    check_eq("t5_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_no_pop_before", 32'(pop_cnt - base_pop), 32'd0);
    begin_frame(8'h5A, 8'h3C, 16'd1);
    wait_done("t5", t_done);
    check_eq("t5_latency", 32'(t_done - t_start), 32'(2 * CD + 1 + (3 + CK) * WORD_CYC));
    @(negedge clk);
    exp_w = '{16'h5A3C, 16'h0001, 16'h0F0F};
    if (CK != 0) exp_w.push_back(16'h694C);
    check_words("t5");
    check_replies("t5", 3 + CK, 16'hC3C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
